// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with grant locking: the owner keeps the resource while it
// requests, and an optional hold timeout force-releases it when others are waiting.
module rr_lock_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 preempt
);

  localparam int IW = $clog2(N);
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic {IDLE, OWN} state_t;

  state_t          state_reg, state_next;
  logic [N-1:0]    grant_reg, grant_next;
  logic            valid_reg, valid_next;
  logic [IW-1:0]   grant_id_reg, grant_id_next;
  logic            preempt_reg, preempt_next;
  logic [IW-1:0]   ptr_reg, ptr_next;
  logic [HW-1:0]   hold_cnt_reg, hold_cnt_next;

  logic            sel_found;
  logic [IW-1:0]   sel_id;
  logic [N-1:0]    sel_onehot;
  logic            owner_req;
  logic            other_req;
  logic            timeout;
  int              scan_idx;

  // Scan from ptr upward with wrap; the first set request wins.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    scan_idx  = 0;
    for (int i = 0; i < N; i++) begin
      scan_idx = (int'(ptr_reg) + i) % N;
      if (!sel_found && req[scan_idx]) begin
        sel_found = 1'b1;
        sel_id    = IW'(scan_idx);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_onehot
      assign sel_onehot[gi] = sel_found && (sel_id == IW'(gi));
    end
  endgenerate

  assign owner_req = req[grant_id_reg];
  assign other_req = |(req & ~grant_reg);
  assign timeout   = (MAX_HOLD != 0) && (hold_cnt_reg == HW'(MAX_HOLD - 1))
                     && owner_req && other_req;

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    valid_next    = valid_reg;
    grant_id_next = grant_id_reg;
    preempt_next  = 1'b0;
    ptr_next      = ptr_reg;
    hold_cnt_next = hold_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (sel_found) begin
          state_next    = OWN;
          grant_next    = sel_onehot;
          valid_next    = 1'b1;
          grant_id_next = sel_id;
          ptr_next      = (sel_id == IW'(N - 1)) ? '0 : IW'(sel_id + 1'b1);
          hold_cnt_next = '0;
        end
      end
      OWN: begin
        if (!owner_req || timeout) begin
          // Release always passes through IDLE, giving one dead cycle.
          state_next    = IDLE;
          grant_next    = '0;
          valid_next    = 1'b0;
          grant_id_next = '0;
          hold_cnt_next = '0;
          preempt_next  = owner_req;
        end else if (hold_cnt_reg != HW'(MAX_HOLD)) begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
        valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      valid_reg    <= 1'b0;
      grant_id_reg <= '0;
      preempt_reg  <= 1'b0;
      ptr_reg      <= '0;
      hold_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      valid_reg    <= valid_next;
      grant_id_reg <= grant_id_next;
      preempt_reg  <= preempt_next;
      ptr_reg      <= ptr_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  assign grant       = grant_reg;
  assign grant_valid = valid_reg;
  assign grant_id    = grant_id_reg;
  assign preempt     = preempt_reg;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed bench for rr_lock_arbiter (N=4, MAX_HOLD=4): each step queues the
// expected post-edge outputs, and they are popped and checked after the edge.
module tb_rr_lock_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic       preempt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] grant;
    logic       preempt;
    string      tag;
  } exp_t;

  exp_t sb[$];

  rr_lock_arbiter #(.N(4), .MAX_HOLD(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .preempt     (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] idx_of(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  task automatic check_out();
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      failures++;
      $error("FAIL scoreboard_empty observed=0 entries expected>=1");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      assert (grant === e.grant) else begin
        failures++;
        $error("FAIL %s grant observed=%b expected=%b", e.tag, grant, e.grant);
      end
      checks++;
      assert (grant_valid === (e.grant != 4'b0)) else begin
        failures++;
        $error("FAIL %s grant_valid observed=%b expected=%b", e.tag, grant_valid, (e.grant != 4'b0));
      end
      checks++;
      assert (grant_id === idx_of(e.grant)) else begin
        failures++;
        $error("FAIL %s grant_id observed=%0d expected=%0d", e.tag, grant_id, idx_of(e.grant));
      end
      checks++;
      assert (preempt === e.preempt) else begin
        failures++;
        $error("FAIL %s preempt observed=%b expected=%b", e.tag, preempt, e.preempt);
      end
      $display("step %-10s rst=%b req=%b grant=%b id=%0d preempt=%b", e.tag, rst, req, grant, grant_id, preempt);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] eg,
                      input logic ep, input string tag);
    exp_t e;
    rst = r;
    req = rq;
    e.grant   = eg;
    e.preempt = ep;
    e.tag     = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;

    // Reset held with all requesting
    step(1, 4'b1111, 4'b0000, 0, "rst0");
    step(1, 4'b1111, 4'b0000, 0, "rst1");
    step(1, 4'b1111, 4'b0000, 0, "rst2");
    step(0, 4'b1111, 4'b0001, 0, "rel");

    // Rotation: each owner holds 2 cycles, drops for one
    step(0, 4'b1111, 4'b0001, 0, "rot0b");
    step(0, 4'b1110, 4'b0000, 0, "rot0d");
    step(0, 4'b1111, 4'b0010, 0, "rot1a");
    step(0, 4'b1111, 4'b0010, 0, "rot1b");
    step(0, 4'b1101, 4'b0000, 0, "rot1d");
    step(0, 4'b1111, 4'b0100, 0, "rot2a");
    step(0, 4'b1111, 4'b0100, 0, "rot2b");
    step(0, 4'b1011, 4'b0000, 0, "rot2d");
    step(0, 4'b1111, 4'b1000, 0, "rot3a");
    step(0, 4'b1111, 4'b1000, 0, "rot3b");
    step(0, 4'b0111, 4'b0000, 0, "rot3d");
    step(0, 4'b1111, 4'b0001, 0, "rot0a");
    step(0, 4'b0000, 4'b0000, 0, "rot0d2");

    // Wrap: grant 3, release, then 1001 must go to 0
    step(0, 4'b1000, 4'b1000, 0, "wrap3");
    step(0, 4'b0000, 4'b0000, 0, "wrapd");
    step(0, 4'b1001, 4'b0001, 0, "wrap0");

    // Timeout: owner 0 already granted one cycle, contended by 1
    step(0, 4'b0011, 4'b0001, 0, "to_h2");
    step(0, 4'b0011, 4'b0001, 0, "to_h3");
    step(0, 4'b0011, 4'b0001, 0, "to_h4");
    step(0, 4'b0011, 4'b0000, 1, "to_pre");
    step(0, 4'b0011, 4'b0010, 0, "to_g1a");
    step(0, 4'b0011, 4'b0010, 0, "to_g1b");
    step(0, 4'b0011, 4'b0010, 0, "to_g1c");
    step(0, 4'b0011, 4'b0010, 0, "to_g1d");
    step(0, 4'b0011, 4'b0000, 1, "to_pre2");
    step(0, 4'b0011, 4'b0001, 0, "to_g0");

    // Uncontended hold beyond MAX_HOLD
    step(0, 4'b0100, 4'b0000, 0, "unc_d");
    for (int i = 0; i < 20; i++)
      step(0, 4'b0100, 4'b0100, 0, $sformatf("hold%0d", i));

    // Reset mid-grant
    step(0, 4'b0010, 4'b0000, 0, "mid_d");
    step(0, 4'b0010, 4'b0010, 0, "mid_g");
    step(1, 4'b0010, 4'b0000, 0, "mid_rst");
    step(0, 4'b0010, 4'b0010, 0, "mid_rel");

    // Pointer restart: after reset, 1010 must pick 1 (scan from 0)
    step(0, 4'b0000, 4'b0000, 0, "ptr_d");
    step(0, 4'b1000, 4'b1000, 0, "ptr_g3");
    step(1, 4'b1010, 4'b0000, 0, "ptr_rst");
    step(0, 4'b1010, 4'b0010, 0, "ptr_sel1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
